// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared types and constants for the UART receive engine.
//   uart_rx_state_t : receiver FSM state encoding
//   UART_CNT_W      : width of the bit-period counter and clk_div
//   UART_DATA_BITS  : frame payload width
//   UART_MIN_DIV    : smallest usable clocks-per-bit value
package uart_rx_pkg;

    localparam int UART_CNT_W     = 16;
    localparam int UART_DATA_BITS = 8;
    localparam int UART_MIN_DIV   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_baud_counter.sv
// uart_rx_baud_counter
// Bit-period down-counter for the UART receiver.
//   clk, reset_n : clock, async active-low reset
//   en           : count enable (decrements while nonzero)
//   load         : load load_val this cycle (wins over en)
//   load_val     : value to load
//   rx_clks      : current count
//   tick         : rx_clks == 0, i.e. this cycle is a sample point
module uart_rx_baud_counter
    import uart_rx_pkg::*;
#(
    parameter int CNT_W = UART_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] rx_clks,
    output logic             tick
);

    logic [CNT_W-1:0] rx_clks_q;
    logic [CNT_W-1:0] rx_clks0;

    // Decrement carry chain
    assign rx_clks0 = rx_clks_q - CNT_W'(1);
    assign tick     = (rx_clks_q == '0);
    assign rx_clks  = rx_clks_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_clks_q <= '0;
        end else if (load) begin
            rx_clks_q <= load_val;
        end else if (en && !tick) begin
            rx_clks_q <= rx_clks0;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm
// UART receive engine: start-bit detection, mid-bit sampling, LSB-first
// byte assembly, and a valid/ready output with frame/parity/overrun flags.
// Build option: define UART_RX_PARITY_EN to add one even-parity bit per frame.
//   clk, reset_n : clock, async active-low reset
//   rx           : synchronised serial line, idle high
//   clk_div      : clocks per bit (values < 2 behave as 2), latched at start bit
//   data_out     : last received byte
//   valid/ready  : output handshake
//   frame_err    : stop bit of data_out byte was 0
//   parity_err   : parity mismatch on data_out byte (0 without parity build)
//   overrun      : sticky, a byte was overwritten while valid was high
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int CNT_W     = UART_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx,
    input  logic [CNT_W-1:0] clk_div,
    output logic [7:0]       data_out,
    output logic             valid,
    input  logic             ready,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);

    uart_rx_state_t   state_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_clamped;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] rx_clks;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_out_q;
    logic             valid_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             tick;
    logic             cnt_en;
    logic             cnt_load;
    logic             start_det;
    logic             samp;
    logic             accept;
`ifdef UART_RX_PARITY_EN
    logic             par_err_q;
    logic             parity_err_q;
`endif

    assign div_clamped = (clk_div < CNT_W'(UART_MIN_DIV)) ? CNT_W'(UART_MIN_DIV) : clk_div;
    assign start_det   = (state_q == ST_IDLE) && !rx;
    // Counter frozen in IDLE and BREAK; every other state samples on tick.
    assign cnt_en      = (state_q != ST_IDLE) && (state_q != ST_BREAK);
    assign samp        = cnt_en && tick;
    assign cnt_load    = start_det || samp;
    // First load lands the START sample at mid-bit; later loads are full periods.
    assign load_val    = start_det ? ((div_clamped >> 1) - CNT_W'(1)) : (div_q - CNT_W'(1));
    assign accept      = valid_q && ready;

    uart_rx_baud_counter #(.CNT_W(CNT_W)) u_baud (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (cnt_en),
        .load     (cnt_load),
        .load_val (load_val),
        .rx_clks  (rx_clks),
        .tick     (tick)
    );

    // The FSM only needs tick; the raw count is kept for observability.
    logic unused_rx_clks;
    assign unused_rx_clks = ^rx_clks;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // Consumption; a byte landing this cycle overrides below.
            if (accept) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!rx) begin
                        div_q   <= div_clamped;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        bit_idx_q <= '0;
                        state_q   <= rx ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_q[bit_idx_q] <= rx;
                        bit_idx_q          <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        // Even parity: the parity bit equals the XOR of the data.
                        par_err_q <= rx ^ (^shift_q);
                        state_q   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        data_out_q  <= shift_q;
                        frame_err_q <= !rx;
                        valid_q     <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= par_err_q;
`endif
                        if (valid_q && !ready) begin
                            overrun_q <= 1'b1;
                        end
                        // Leaving mid-stop-bit re-arms start detection early.
                        state_q <= rx ? ST_IDLE : ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (rx) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
`timescale 1ns/1ps
module tb_uart_rx_fsm;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int NB  = 10;   // bit periods from START sample to STOP sample
`else
    localparam bit PAR = 1'b0;
    localparam int NB  = 9;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic        ready = 1'b1;
    logic [15:0] clk_div = 16'd16;
    logic [7:0]  data_out;
    logic        valid, frame_err, parity_err, overrun;

    uart_rx_fsm #(.DATA_BITS(8), .CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .clk_div    (clk_div),
        .data_out   (data_out),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every rising edge of valid, count valid-high cycles.
    typedef struct { int c; logic [7:0] d; logic fe; logic pe; } ev_t;
    ev_t  evq[$];
    logic vprev = 1'b0;
    int   vhigh = 0;
    always @(negedge clk) begin
        if (valid && !vprev) evq.push_back('{cyc, data_out, frame_err, parity_err});
        if (valid) vhigh++;
        vprev = valid;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int eff_div(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    // Edge of STOP sample = start edge + D/2 + NB*D; sc is the cycle count
    // at the negedge where the start bit was driven (start edge is sc+1).
    function automatic int exp_rise(input int sc, input int div);
        int d;
        d = eff_div(div);
        return sc + 1 + (d >> 1) + NB * d;
    endfunction

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic pbit, input logic sbit,
                        input int div, input int slen, output int sc);
        int d;
        d = eff_div(div);
        clk_div = 16'(div);
        @(negedge clk);
        rx = 1'b0;
        sc = cyc;
        repeat (d) @(negedge clk);
        clk_div = 16'($urandom_range(0, 60));   // must be ignored mid-frame
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (d) @(negedge clk);
        end
        if (PAR) begin
            rx = pbit;
            repeat (d) @(negedge clk);
        end
        rx = sbit;
        repeat (slen) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic expect_byte(input string nm, input logic [7:0] d, input logic fe,
                               input logic pe, input int rc);
        int w;
        ev_t ev;
        w = 0;
        #1;
        while (evq.size() == 0 && w < 400) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (evq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: actual=no byte required=%0h", nm, d);
        end else begin
            ev = evq.pop_front();
            chk({nm, ".data"}, 32'(ev.d), 32'(d));
            chk({nm, ".ferr"}, 32'(ev.fe), 32'(fe));
            chk({nm, ".perr"}, 32'(ev.pe), 32'(pe));
            chk({nm, ".cycle"}, 32'(ev.c), 32'(rc));
        end
    endtask

    typedef struct {
        logic [7:0] b; logic pbit; logic sbit; int div; int slen;
        logic [7:0] exp_d; logic exp_fe; logic exp_pe; string nm;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc, v0, d;
        logic [7:0] b, pat;
        logic pb, sb;

        tbl[0] = '{8'hA5, 1'b0, 1'b1, 16, 16, 8'hA5, 1'b0, 1'b0, "a5_basic"};
        tbl[1] = '{8'h3C, 1'b0, 1'b0, 16, 40, 8'h3C, 1'b1, 1'b0, "3c_break"};
        tbl[2] = '{8'h55, 1'b0, 1'b1, 16, 16, 8'h55, 1'b0, 1'b0, "55_after_break"};
        tbl[3] = '{8'h01, 1'b0, 1'b1, 16, 16, 8'h01, 1'b0, PAR,  "01_badpar"};
        tbl[4] = '{8'h03, 1'b0, 1'b1, 16, 16, 8'h03, 1'b0, 1'b0, "03_goodpar"};
        tbl[5] = '{8'h96, 1'b0, 1'b1, 1,  2,  8'h96, 1'b0, 1'b0, "div1_clamp"};
        tbl[6] = '{8'h80, 1'b1, 1'b1, 0,  2,  8'h80, 1'b0, 1'b0, "div0_clamp"};
        tbl[7] = '{8'hFF, 1'b1, 1'b1, 3,  3,  8'hFF, 1'b0, PAR,  "div3_odd"};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.data_out", 32'(data_out), 32'h0);
        chk("rst.valid", 32'(valid), 32'h0);
        chk("rst.frame_err", 32'(frame_err), 32'h0);
        chk("rst.parity_err", 32'(parity_err), 32'h0);
        chk("rst.overrun", 32'(overrun), 32'h0);
        reset_n = 1'b1;
        idle(4);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            v0 = vhigh;
            send(tbl[i].b, tbl[i].pbit, tbl[i].sbit, tbl[i].div, tbl[i].slen, sc);
            idle(3);
            expect_byte(tbl[i].nm, tbl[i].exp_d, tbl[i].exp_fe, tbl[i].exp_pe,
                        exp_rise(sc, tbl[i].div));
            chk({tbl[i].nm, ".valid_cycles"}, 32'(vhigh - v0), 32'd1);
        end

        // Glitch: 3 low cycles, no byte
        clk_div = 16'd16;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(40);
        #1;
        chk("glitch.no_event", 32'(evq.size()), 32'd0);
        chk("glitch.valid", 32'(valid), 32'd0);

        // Overrun: two bytes with ready low, then one ready pulse
        ready = 1'b0;
        send(8'h11, ^8'h11, 1'b1, 16, 16, sc);
        idle(3);
        expect_byte("ovr.first", 8'h11, 1'b0, 1'b0, exp_rise(sc, 16));
        chk("ovr.no_overrun_yet", 32'(overrun), 32'd0);
        send(8'h22, ^8'h22, 1'b1, 16, 16, sc);
        idle(3);
        chk("ovr.data", 32'(data_out), 32'h22);
        chk("ovr.valid", 32'(valid), 32'd1);
        chk("ovr.overrun", 32'(overrun), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("ovr.valid_cleared", 32'(valid), 32'd0);
        chk("ovr.overrun_cleared", 32'(overrun), 32'd0);
        ready = 1'b1;
        idle(2);

        // Reset during DATA bit 4
        pat = 8'hFF;
        clk_div = 16'd16;
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            rx = pat[k];
            repeat (16) @(negedge clk);
        end
        rx = pat[4];
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst.data_out", 32'(data_out), 32'h0);
        chk("mid_rst.valid", 32'(valid), 32'h0);
        reset_n = 1'b1;
        idle(20);
        #1;
        chk("mid_rst.no_partial", 32'(evq.size()), 32'd0);
        send(8'h7E, ^8'h7E, 1'b1, 16, 16, sc);
        idle(3);
        expect_byte("mid_rst.7e", 8'h7E, 1'b0, 1'b0, exp_rise(sc, 16));

        // Randomized frames against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            b  = 8'($urandom);
            pb = 1'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            d  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 24));
            v0 = vhigh;
            send(b, pb, sb, d, sb ? eff_div(d) : eff_div(d) + int'($urandom_range(0, 20)), sc);
            idle(int'($urandom_range(2, 6)));
            expect_byte($sformatf("rand%0d", i), b, !sb, PAR & (pb ^ (^b)), exp_rise(sc, d));
            chk($sformatf("rand%0d.valid_cycles", i), 32'(vhigh - v0), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
